rv32_mem_arbiter: RTL

//   Parametrised N-master arbiter in front of a single-port synchronous SRAM macro.

---
 rtl/rv32_mem_arbiter_pkg.sv | 17 +
 rtl/rv32_rr_picker.sv | 39 +++
 rtl/rv32_mem_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/rv32_mem_arbiter_pkg.sv
// Shared types and helpers for the SRAM arbiter: arbitration mode and port bounds.
package rv32_mem_arbiter_pkg;

  typedef enum logic [0:0] {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int ARB_MAX_PORTS = 8;
  localparam int ARB_IDX_W     = $clog2(ARB_MAX_PORTS);

  function automatic logic [ARB_MAX_PORTS-1:0] port_onehot(input logic [ARB_IDX_W-1:0] idx);
    port_onehot      = '0;
    port_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rv32_rr_picker.sv
// Combinational rotating priority picker: lowest eligible index at or after ptr+1 wins.
module rv32_rr_picker #(
  parameter int NUM_PORTS = 4,
  parameter int PW        = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] mask,
  input  logic [PW-1:0]        ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [PW-1:0]        idx,
  output logic                 vld
);

  logic [NUM_PORTS-1:0]   eligible;
  logic [NUM_PORTS-1:0]   rot;
  logic [2*NUM_PORTS-1:0] dbl;
  logic [PW:0]            shamt;
  logic [PW:0]            enc;
  logic [PW+1:0]          sum;

  // Rotate so ptr+1 lands at bit 0, pick the lowest set bit, then rotate the index back.
  always_comb begin
    eligible = req & ~mask;
    shamt    = {1'b0, ptr} + (PW+1)'(1);
    dbl      = {eligible, eligible};
    rot      = dbl[shamt +: NUM_PORTS];
    vld      = |rot;
    enc      = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (rot[i]) enc = (PW+1)'(i);
    end
    sum = {1'b0, enc} + {1'b0, shamt};
    if (sum >= (PW+2)'(NUM_PORTS)) sum = sum - (PW+2)'(NUM_PORTS);
    idx = PW'(sum);
    gnt = '0;
    if (vld) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/rv32_mem_arbiter.sv
// N-master arbiter in front of a single-port synchronous SRAM, with bus lock,
// bounded hold, byte strobes, one-cycle read return and out-of-range error.
module rv32_mem_arbiter
  import rv32_mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 16,
  parameter int MEM_DEPTH = 16384,
  parameter int ARB_MODE  = 1,
  parameter int MAX_HOLD  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS-1:0]          lock,
  input  logic [NUM_PORTS-1:0]          we,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
  input  logic [NUM_PORTS*DATA_W/8-1:0] be,
  input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
  output logic [NUM_PORTS-1:0]          gnt,
  output logic [NUM_PORTS-1:0]          rvalid,
  output logic [NUM_PORTS-1:0]          rerr,
  output logic [DATA_W-1:0]             rdata,
  output logic                          mem_cs,
  output logic                          mem_we,
  output logic [DATA_W/8-1:0]           mem_be,
  output logic [$clog2(MEM_DEPTH)-1:0]  mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata
);

  localparam int BE_W    = DATA_W / 8;
  localparam int MA_W    = $clog2(MEM_DEPTH);
  localparam int PW      = $clog2(NUM_PORTS);
  localparam int BYTE_SH = $clog2(BE_W);
  localparam int HW      = $clog2(MAX_HOLD + 1);
  localparam bit RR_EN   = (ARB_MODE == int'(ARB_RR));
  localparam logic [PW-1:0] LAST_PORT  = PW'(NUM_PORTS - 1);
  localparam logic [63:0]   ADDR_LIMIT = 64'(MEM_DEPTH) * 64'(BE_W);

  function automatic logic [NUM_PORTS-1:0] to_onehot(input logic [PW-1:0] i);
    return NUM_PORTS'(port_onehot(ARB_IDX_W'(i)));
  endfunction

  logic                 owner_vld;
  logic [PW-1:0]        owner_idx;
  logic [HW-1:0]        hold_cnt;
  logic [PW-1:0]        rr_ptr;
  logic [NUM_PORTS-1:0] owner_oh;
  logic                 owner_req;
  logic                 hold_full;
  logic                 force_owner;
  logic [NUM_PORTS-1:0] pick_mask;
  logic [NUM_PORTS-1:0] pick_gnt;
  logic [PW-1:0]        pick_idx;
  logic                 pick_vld;
  logic                 win_vld;
  logic [PW-1:0]        win_idx;
  logic [ADDR_W-1:0]    sel_addr;
  logic                 sel_we;
  logic                 sel_oor;

  logic                 vld_p1;
  logic [PW-1:0]        idx_p1;
  logic                 rd_p1;
  logic                 err_p1;

  assign owner_oh  = to_onehot(owner_idx);
  assign owner_req = owner_vld && req[owner_idx];
  assign hold_full = (hold_cnt >= HW'(MAX_HOLD));

  // A saturated owner steps aside for one arbitration only if someone else is waiting.
  always_comb begin
    force_owner = 1'b0;
    pick_mask   = '0;
    if (owner_req) begin
      if (!hold_full || (req & ~owner_oh) == '0) force_owner = 1'b1;
      else                                        pick_mask   = owner_oh;
    end
  end

  rv32_rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .PW        (PW)
  ) u_picker (
    .req  (req),
    .mask (pick_mask),
    .ptr  (RR_EN ? rr_ptr : LAST_PORT),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .vld  (pick_vld)
  );

  assign win_vld = rst_n && (force_owner || pick_vld);
  assign win_idx = force_owner ? owner_idx : pick_idx;
  assign gnt     = win_vld ? to_onehot(win_idx) : '0;

  assign sel_addr  = addr[win_idx*ADDR_W +: ADDR_W];
  assign sel_we    = we[win_idx];
  assign sel_oor   = (64'(sel_addr) >= ADDR_LIMIT);
  assign mem_cs    = win_vld && !sel_oor;
  assign mem_we    = mem_cs && sel_we;
  assign mem_be    = mem_we ? be[win_idx*BE_W +: BE_W] : '0;
  assign mem_addr  = MA_W'(sel_addr >> BYTE_SH);
  assign mem_wdata = wdata[win_idx*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_vld <= 1'b0;
      owner_idx <= '0;
      hold_cnt  <= '0;
      rr_ptr    <= LAST_PORT;
    end else if (win_vld) begin
      rr_ptr <= win_idx;
      if (lock[win_idx]) begin
        owner_vld <= 1'b1;
        owner_idx <= win_idx;
        if (owner_vld && owner_idx == win_idx) begin
          if (!hold_full) hold_cnt <= hold_cnt + HW'(1);
        end else begin
          hold_cnt <= HW'(1);
        end
      end else begin
        owner_vld <= 1'b0;
        hold_cnt  <= '0;
      end
    end else begin
      owner_vld <= 1'b0;
      hold_cnt  <= '0;
    end
  end

  // p1: response pipe, one cycle behind the grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      idx_p1 <= '0;
      rd_p1  <= 1'b0;
      err_p1 <= 1'b0;
    end else begin
      vld_p1 <= win_vld;
      idx_p1 <= win_idx;
      rd_p1  <= !sel_we;
      err_p1 <= sel_oor;
    end
  end

  assign rvalid = (vld_p1 && (rd_p1 || err_p1)) ? to_onehot(idx_p1) : '0;
  assign rerr   = (vld_p1 && err_p1) ? to_onehot(idx_p1) : '0;
  assign rdata  = (vld_p1 && rd_p1 && !err_p1) ? mem_rdata : '0;

endmodule
